// File: rtl/pipeline_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_unit
//
// Hazard and forwarding controller for the 5-stage pipeline. Sits beside the
// ID-stage decoder and drives the operand forwarding muxes plus the
// PC / IF-ID / ID-EX / EX-MEM / MEM-WB enables.
//
// Handles:
//   - EX/MEM operand forwarding (or stall-until-retired when FWD_ENABLE = 0)
//   - load-use and branch-operand stalls
//   - data-memory wait freeze using the MIO ready handshake
//   - a configurable number of IF/ID flush slots after a taken jump/branch
//
// The pipeline controls (holds, bubbles, flush, forwarding selects) are
// combinational because they must act in the same cycle as the hazard. They
// are forced low while rst_n is asserted. The state and mem_timeout outputs
// are registered.
//
// Ports:
//   clk, rst_n                   pipeline clock, async active-low reset
//   id_rs, id_rt                 source registers of the ID instruction
//   id_uses_rs, id_uses_rt       ID instruction reads rs / rt
//   id_is_branch                 ID compares operands (beq/bne/jr)
//   id_take                      ID resolves a taken jump or branch
//   ex_we, ex_is_load, ex_waddr  EX writeback info
//   mem_we, mem_is_load, mem_waddr  MEM writeback info
//   mem_req, mio_ready           data-memory access and completion
//   fwd_a_sel, fwd_b_sel         00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load
//   pc_hold, ifid_hold           hold PC / IF-ID
//   idex_bubble                  load NOP into ID/EX
//   ifid_flush                   replace IF/ID with NOP
//   exmem_hold, memwb_bubble     freeze EX/MEM, insert NOP into MEM/WB
//   state                        00 RUN, 01 STALL, 10 MEM_WAIT, 11 FLUSH
//   mem_timeout                  sticky: a memory wait reached MEM_WAIT_MAX
//
// State | meaning
//   RUN      | pipeline advancing normally
//   STALL    | previous cycle held ID for a data hazard
//   MEM_WAIT | previous cycle froze for an outstanding memory access
//   FLUSH    | post-branch flush slots still pending
// -----------------------------------------------------------------------------
module pipeline_hazard_unit #(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned FLUSH_SLOTS  = 1,
    parameter int unsigned FWD_ENABLE   = 1,
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_is_branch,
    input  logic                  id_take,
    input  logic                  ex_we,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_waddr,
    input  logic                  mem_we,
    input  logic                  mem_is_load,
    input  logic [REG_ADDR_W-1:0] mem_waddr,
    input  logic                  mem_req,
    input  logic                  mio_ready,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  pc_hold,
    output logic                  ifid_hold,
    output logic                  idex_bubble,
    output logic                  ifid_flush,
    output logic                  exmem_hold,
    output logic                  memwb_bubble,
    output logic [1:0]            state,
    output logic                  mem_timeout
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_STALL    = 2'b01,
        ST_MEM_WAIT = 2'b10,
        ST_FLUSH    = 2'b11
    } state_t;

    // The flush counter holds the number of flush slots still owed after the
    // current one, so the id_take cycle itself accounts for the first slot.
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_SLOTS - 1);
    localparam logic [7:0] WAIT_MAX     = 8'(MEM_WAIT_MAX);
    localparam logic       NO_FWD       = (FWD_ENABLE == 0);

    state_t     state_q;
    logic [2:0] flush_cnt;
    logic [7:0] wait_cnt;

    logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
    logic ex_hit, mem_hit;
    logic data_stall, mem_wait;
    logic flush_pend, take_now, flush_now;
    logic [7:0] wait_inc;

    // ---------------------------------------------------------------- matches
    assign ex_hit_a  = ex_we  && (ex_waddr  != '0) && id_uses_rs && (id_rs == ex_waddr);
    assign ex_hit_b  = ex_we  && (ex_waddr  != '0) && id_uses_rt && (id_rt == ex_waddr);
    assign mem_hit_a = mem_we && (mem_waddr != '0) && id_uses_rs && (id_rs == mem_waddr);
    assign mem_hit_b = mem_we && (mem_waddr != '0) && id_uses_rt && (id_rt == mem_waddr);
    assign ex_hit    = ex_hit_a  | ex_hit_b;
    assign mem_hit   = mem_hit_a | mem_hit_b;

    // ------------------------------------------------------------- forwarding
    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (!NO_FWD && rst_n) begin
            if (ex_hit_a)
                fwd_a_sel = 2'b01;
            else if (mem_hit_a)
                fwd_a_sel = mem_is_load ? 2'b11 : 2'b10;
            if (ex_hit_b)
                fwd_b_sel = 2'b01;
            else if (mem_hit_b)
                fwd_b_sel = mem_is_load ? 2'b11 : 2'b10;
        end
    end

    // ---------------------------------------------------------------- hazards
    // Load data is only available after MEM, and branch operands are compared
    // in ID, so those cases cannot be covered by the EX-stage forwarding muxes.
    assign data_stall = (ex_hit & (ex_is_load | id_is_branch))
                      | (mem_hit & mem_is_load & id_is_branch)
                      | (NO_FWD & (ex_hit | mem_hit));

    assign mem_wait   = mem_req & ~mio_ready;

    // While flush slots are pending, ID holds a squashed slot whose id_take
    // must not restart the flush sequence.
    assign flush_pend = (flush_cnt != 3'd0);
    assign take_now   = id_take & ~flush_pend;
    assign flush_now  = ~mem_wait & ~data_stall & (flush_pend | take_now);

    // ---------------------------------------------------- pipeline controls
    assign pc_hold      = rst_n & (mem_wait | data_stall);
    assign ifid_hold    = rst_n & (mem_wait | data_stall);
    assign idex_bubble  = rst_n & ~mem_wait & data_stall;
    assign ifid_flush   = rst_n & flush_now;
    assign exmem_hold   = rst_n & mem_wait;
    assign memwb_bubble = rst_n & mem_wait;

    assign wait_inc = (wait_cnt >= WAIT_MAX) ? wait_cnt : wait_cnt + 8'd1;

    // -------------------------------------------------------------------- FSM
    // A memory wait during FLUSH leaves flush_cnt untouched, so the remaining
    // slots resume once mio_ready arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            flush_cnt   <= 3'd0;
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
        end else begin
            if (mem_wait) begin
                state_q  <= ST_MEM_WAIT;
                wait_cnt <= wait_inc;
                if (wait_inc >= WAIT_MAX)
                    mem_timeout <= 1'b1;
            end else begin
                wait_cnt <= 8'd0;
                if (data_stall) begin
                    state_q <= ST_STALL;
                end else if (flush_pend) begin
                    flush_cnt <= flush_cnt - 3'd1;
                    state_q   <= (flush_cnt > 3'd1) ? ST_FLUSH : ST_RUN;
                end else if (id_take) begin
                    flush_cnt <= FLUSH_RELOAD;
                    state_q   <= (FLUSH_RELOAD != 3'd0) ? ST_FLUSH : ST_RUN;
                end else begin
                    state_q <= ST_RUN;
                end
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
module tb_pipeline_hazard_unit;

    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_STALL = 6'b111000;
    localparam logic [5:0] C_FLUSH = 6'b000100;
    localparam logic [5:0] C_WAIT  = 6'b110011;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_waddr, mem_waddr;
    logic       id_uses_rs, id_uses_rt, id_is_branch, id_take;
    logic       ex_we, ex_is_load, mem_we, mem_is_load, mem_req, mio_ready;

    logic [1:0] a_fwd_a, a_fwd_b, a_state;
    logic       a_pc_hold, a_ifid_hold, a_idex_bubble, a_ifid_flush;
    logic       a_exmem_hold, a_memwb_bubble, a_timeout;
    logic [1:0] n_fwd_a, n_fwd_b, n_state;
    logic       n_pc_hold, n_ifid_hold, n_idex_bubble, n_ifid_flush;
    logic       n_exmem_hold, n_memwb_bubble, n_timeout;
    logic [5:0] a_ctrl, n_ctrl;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign a_ctrl = {a_pc_hold, a_ifid_hold, a_idex_bubble, a_ifid_flush, a_exmem_hold, a_memwb_bubble};
    assign n_ctrl = {n_pc_hold, n_ifid_hold, n_idex_bubble, n_ifid_flush, n_exmem_hold, n_memwb_bubble};

    pipeline_hazard_unit #(
        .REG_ADDR_W(5), .FLUSH_SLOTS(3), .FWD_ENABLE(1), .MEM_WAIT_MAX(3)
    ) u_fwd (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_branch(id_is_branch), .id_take(id_take),
        .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr),
        .mem_we(mem_we), .mem_is_load(mem_is_load), .mem_waddr(mem_waddr),
        .mem_req(mem_req), .mio_ready(mio_ready),
        .fwd_a_sel(a_fwd_a), .fwd_b_sel(a_fwd_b),
        .pc_hold(a_pc_hold), .ifid_hold(a_ifid_hold), .idex_bubble(a_idex_bubble),
        .ifid_flush(a_ifid_flush), .exmem_hold(a_exmem_hold), .memwb_bubble(a_memwb_bubble),
        .state(a_state), .mem_timeout(a_timeout)
    );

    pipeline_hazard_unit #(
        .REG_ADDR_W(5), .FLUSH_SLOTS(1), .FWD_ENABLE(0), .MEM_WAIT_MAX(15)
    ) u_nofwd (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_branch(id_is_branch), .id_take(id_take),
        .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr),
        .mem_we(mem_we), .mem_is_load(mem_is_load), .mem_waddr(mem_waddr),
        .mem_req(mem_req), .mio_ready(mio_ready),
        .fwd_a_sel(n_fwd_a), .fwd_b_sel(n_fwd_b),
        .pc_hold(n_pc_hold), .ifid_hold(n_ifid_hold), .idex_bubble(n_idex_bubble),
        .ifid_flush(n_ifid_flush), .exmem_hold(n_exmem_hold), .memwb_bubble(n_memwb_bubble),
        .state(n_state), .mem_timeout(n_timeout)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle();
        id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0;
        id_is_branch = 0; id_take = 0;
        ex_we = 0; ex_is_load = 0; ex_waddr = '0;
        mem_we = 0; mem_is_load = 0; mem_waddr = '0;
        mem_req = 0; mio_ready = 0;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic br, input logic take);
        id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_is_branch = br; id_take = take;
    endtask

    task automatic set_ex(input logic we, input logic ld, input logic [4:0] wa);
        ex_we = we; ex_is_load = ld; ex_waddr = wa;
    endtask

    task automatic set_mem(input logic we, input logic ld, input logic [4:0] wa,
                           input logic req, input logic rdy);
        mem_we = we; mem_is_load = ld; mem_waddr = wa; mem_req = req; mio_ready = rdy;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset with hazard-provoking inputs: every control must stay low.
        rst_n = 1'b0;
        idle();
        set_mem(0, 0, 5'd0, 1, 0);
        set_ex(1, 1, 5'd3);
        set_id(5'd3, 5'd0, 1, 0, 0, 1);
        #12;
        check("rst_ctrl", 8'(a_ctrl), 8'(C_NONE));
        check("rst_state", 8'(a_state), 8'd0);
        check("rst_fwd_a", 8'(a_fwd_a), 8'd0);
        check("rst_timeout", 8'(a_timeout), 8'd0);
        #5;
        idle();
        rst_n = 1'b1;

        // EX ALU forwarding to both operands
        next_cyc(); set_ex(1, 0, 5'd3); set_id(5'd3, 5'd3, 1, 1, 0, 0);
        @(negedge clk);
        check("ex_fwd_a", 8'(a_fwd_a), 8'd1);
        check("ex_fwd_b", 8'(a_fwd_b), 8'd1);
        check("ex_fwd_ctrl", 8'(a_ctrl), 8'(C_NONE));

        // MEM ALU forwarding
        next_cyc(); set_mem(1, 0, 5'd3, 0, 0); set_id(5'd3, 5'd3, 1, 1, 0, 0);
        @(negedge clk);
        check("mem_fwd_a", 8'(a_fwd_a), 8'd2);
        check("mem_fwd_b", 8'(a_fwd_b), 8'd2);
        check("mem_fwd_state", 8'(a_state), 8'd0);

        // EX priority over MEM; rt from MEM load data
        next_cyc(); set_ex(1, 0, 5'd3); set_mem(1, 1, 5'd6, 0, 0); set_id(5'd3, 5'd6, 1, 1, 0, 0);
        @(negedge clk);
        check("mix_fwd_a", 8'(a_fwd_a), 8'd1);
        check("mix_fwd_b", 8'(a_fwd_b), 8'd3);
        next_cyc(); set_ex(1, 0, 5'd6); set_mem(1, 1, 5'd6, 0, 0); set_id(5'd6, 5'd0, 1, 0, 0, 0);
        @(negedge clk);
        check("prio_fwd_a", 8'(a_fwd_a), 8'd1);

        // Writes to $0 never match, even for a load feeding a branch
        next_cyc(); set_ex(1, 1, 5'd0); set_mem(1, 1, 5'd0, 0, 0); set_id(5'd0, 5'd0, 1, 1, 1, 0);
        @(negedge clk);
        check("r0_fwd_a", 8'(a_fwd_a), 8'd0);
        check("r0_fwd_b", 8'(a_fwd_b), 8'd0);
        check("r0_ctrl", 8'(a_ctrl), 8'(C_NONE));

        // Unused operand does not match
        next_cyc(); set_ex(1, 1, 5'd9); set_id(5'd9, 5'd9, 0, 0, 0, 0);
        @(negedge clk);
        check("unused_ctrl", 8'(a_ctrl), 8'(C_NONE));
        check("unused_fwd_a", 8'(a_fwd_a), 8'd0);

        // Load-use: one stall, then load data forwarded from MEM
        next_cyc(); set_ex(1, 1, 5'd5); set_id(5'd5, 5'd0, 1, 0, 0, 0);
        @(negedge clk);
        check("lu_ctrl", 8'(a_ctrl), 8'(C_STALL));
        check("lu_state0", 8'(a_state), 8'd0);
        next_cyc(); set_mem(1, 1, 5'd5, 0, 0); set_id(5'd5, 5'd0, 1, 0, 0, 0);
        @(negedge clk);
        check("lu_state1", 8'(a_state), 8'd1);
        check("lu_fwd_a", 8'(a_fwd_a), 8'd3);
        check("lu_ctrl1", 8'(a_ctrl), 8'(C_NONE));
        next_cyc();
        @(negedge clk);
        check("lu_state2", 8'(a_state), 8'd0);

        // Branch operand hazards
        next_cyc(); set_ex(1, 0, 5'd8); set_id(5'd8, 5'd0, 1, 0, 1, 0);
        @(negedge clk);
        check("br_ex_ctrl", 8'(a_ctrl), 8'(C_STALL));
        next_cyc(); set_mem(1, 1, 5'd8, 0, 0); set_id(5'd8, 5'd0, 1, 0, 1, 0);
        @(negedge clk);
        check("br_memld_ctrl", 8'(a_ctrl), 8'(C_STALL));
        check("br_memld_state", 8'(a_state), 8'd1);
        next_cyc(); set_mem(1, 0, 5'd8, 0, 0); set_id(5'd8, 5'd0, 1, 0, 1, 0);
        @(negedge clk);
        check("br_memalu_ctrl", 8'(a_ctrl), 8'(C_NONE));
        check("br_memalu_fwd", 8'(a_fwd_a), 8'd2);
        next_cyc();
        @(negedge clk);
        check("br_state_end", 8'(a_state), 8'd0);

        // Taken branch: three flush cycles, two of them in FLUSH
        next_cyc(); set_id(5'd0, 5'd0, 0, 0, 0, 1);
        @(negedge clk);
        check("fl0_ctrl", 8'(a_ctrl), 8'(C_FLUSH));
        check("fl0_state", 8'(a_state), 8'd0);
        next_cyc();
        @(negedge clk);
        check("fl1_ctrl", 8'(a_ctrl), 8'(C_FLUSH));
        check("fl1_state", 8'(a_state), 8'd3);
        next_cyc();
        @(negedge clk);
        check("fl2_ctrl", 8'(a_ctrl), 8'(C_FLUSH));
        check("fl2_state", 8'(a_state), 8'd3);
        next_cyc();
        @(negedge clk);
        check("fl3_ctrl", 8'(a_ctrl), 8'(C_NONE));
        check("fl3_state", 8'(a_state), 8'd0);

        // Memory wait: 4 wait cycles, timeout after the 3rd, sticky after ready
        for (int i = 1; i <= 4; i++) begin
            next_cyc(); set_mem(0, 0, 5'd0, 1, 0);
            @(negedge clk);
            check($sformatf("mw%0d_ctrl", i), 8'(a_ctrl), 8'(C_WAIT));
            check($sformatf("mw%0d_state", i), 8'(a_state), (i == 1) ? 8'd0 : 8'd2);
            check($sformatf("mw%0d_timeout", i), 8'(a_timeout), (i == 4) ? 8'd1 : 8'd0);
        end
        next_cyc(); set_mem(0, 0, 5'd0, 1, 1);
        @(negedge clk);
        check("mw_rdy_ctrl", 8'(a_ctrl), 8'(C_NONE));
        check("mw_rdy_state", 8'(a_state), 8'd2);
        next_cyc();
        @(negedge clk);
        check("mw_end_state", 8'(a_state), 8'd0);
        check("mw_sticky", 8'(a_timeout), 8'd1);

        // Wait and stall together, id_take held off until the stall clears
        next_cyc(); set_mem(0, 0, 5'd0, 1, 0); set_ex(1, 1, 5'd5); set_id(5'd5, 5'd0, 1, 0, 0, 1);
        @(negedge clk);
        check("ws1_ctrl", 8'(a_ctrl), 8'(C_WAIT));
        next_cyc(); set_mem(0, 0, 5'd0, 1, 1); set_ex(1, 1, 5'd5); set_id(5'd5, 5'd0, 1, 0, 0, 1);
        @(negedge clk);
        check("ws2_ctrl", 8'(a_ctrl), 8'(C_STALL));
        check("ws2_state", 8'(a_state), 8'd2);
        next_cyc(); set_mem(1, 1, 5'd5, 0, 0); set_id(5'd5, 5'd0, 1, 0, 0, 1);
        @(negedge clk);
        check("ws3_ctrl", 8'(a_ctrl), 8'(C_FLUSH));
        check("ws3_state", 8'(a_state), 8'd1);
        next_cyc();
        @(negedge clk);
        check("ws4_state", 8'(a_state), 8'd3);
        next_cyc();
        @(negedge clk);
        check("ws5_ctrl", 8'(a_ctrl), 8'(C_FLUSH));
        next_cyc();
        @(negedge clk);
        check("ws6_ctrl", 8'(a_ctrl), 8'(C_NONE));

        // Memory wait inside FLUSH freezes the remaining slots
        next_cyc(); set_id(5'd0, 5'd0, 0, 0, 0, 1);
        @(negedge clk);
        check("fw0_ctrl", 8'(a_ctrl), 8'(C_FLUSH));
        next_cyc(); set_mem(0, 0, 5'd0, 1, 0);
        @(negedge clk);
        check("fw1_ctrl", 8'(a_ctrl), 8'(C_WAIT));
        check("fw1_state", 8'(a_state), 8'd3);
        next_cyc(); set_mem(0, 0, 5'd0, 1, 1);
        @(negedge clk);
        check("fw2_ctrl", 8'(a_ctrl), 8'(C_FLUSH));
        check("fw2_state", 8'(a_state), 8'd2);
        next_cyc();
        @(negedge clk);
        check("fw3_ctrl", 8'(a_ctrl), 8'(C_FLUSH));
        check("fw3_state", 8'(a_state), 8'd3);
        next_cyc();
        @(negedge clk);
        check("fw4_ctrl", 8'(a_ctrl), 8'(C_NONE));
        check("fw4_state", 8'(a_state), 8'd0);

        // Asynchronous reset in the middle of FLUSH
        next_cyc(); set_id(5'd0, 5'd0, 0, 0, 0, 1);
        next_cyc();
        @(negedge clk);
        check("rf_state_pre", 8'(a_state), 8'd3);
        set_mem(0, 0, 5'd0, 1, 0); set_ex(1, 0, 5'd4); set_id(5'd4, 5'd0, 1, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rf_ctrl", 8'(a_ctrl), 8'(C_NONE));
        check("rf_state", 8'(a_state), 8'd0);
        check("rf_fwd_a", 8'(a_fwd_a), 8'd0);
        check("rf_timeout", 8'(a_timeout), 8'd0);
        @(posedge clk);
        #1;
        check("rf_state_hold", 8'(a_state), 8'd0);
        idle();
        rst_n = 1'b1;

        // No-forwarding instance: stall through EX and MEM, selects stay 00
        next_cyc(); set_ex(1, 0, 5'd7); set_id(5'd7, 5'd0, 1, 0, 0, 0);
        @(negedge clk);
        check("nf1_ctrl", 8'(n_ctrl), 8'(C_STALL));
        check("nf1_fwd_a", 8'(n_fwd_a), 8'd0);
        check("nf1_fwd_ref", 8'(a_fwd_a), 8'd1);
        next_cyc(); set_mem(1, 0, 5'd7, 0, 0); set_id(5'd7, 5'd0, 1, 0, 0, 0);
        @(negedge clk);
        check("nf2_ctrl", 8'(n_ctrl), 8'(C_STALL));
        check("nf2_state", 8'(n_state), 8'd1);
        check("nf2_fwd_a", 8'(n_fwd_a), 8'd0);
        next_cyc();
        @(negedge clk);
        check("nf3_ctrl", 8'(n_ctrl), 8'(C_NONE));
        check("nf3_state", 8'(n_state), 8'd1);
        next_cyc();
        @(negedge clk);
        check("nf4_state", 8'(n_state), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
